// File: rtl/ccu_ep_merge.sv
// Registered end-pulse / sign-pulse merger: masks N_EP end pulses, captures the lowest source index and holds it until ep_ack.
// One-cycle latency on every output with no combinational input path. No backpressure: overruns are flagged and counted.
module ccu_ep_merge #(
    parameter int N_EP   = 12,
    parameter int N_ONES = 3,
    parameter int CNT_W  = 4,
    localparam int SW    = (N_EP > 1) ? $clog2(N_EP) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_EP-1:0]   ep_in,
    input  logic [N_EP-1:0]   ep_en,
    input  logic [N_ONES-1:0] ones_in,
    input  logic              ep_ack,
    input  logic              clr_err,
    output logic              ep,
    output logic              ep_pending,
    output logic [SW-1:0]     ep_src,
    output logic              ccu_ones,
    output logic              multi_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  overrun_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state;
    logic [N_EP-1:0] hit;
    logic            any_hit;
    logic            multi_hit;
    logic [SW-1:0]   low_idx;
    logic            capture;
    logic            ovr_event;

    assign hit       = ep_in & ep_en;
    assign any_hit   = |hit;
    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign multi_hit = |(hit & (hit - N_EP'(1)));

    always_comb begin
        low_idx = '0;
        for (int i = N_EP - 1; i >= 0; i--) begin
            if (hit[i]) begin
                low_idx = SW'(i);
            end
        end
    end

    // An ack in the same cycle as a new pulse frees the slot, so it is a fresh capture, not an overrun.
    assign capture   = any_hit && ((state == IDLE) || ep_ack);
    assign ovr_event = any_hit && (state == PEND) && !ep_ack;

    assign ep_pending = (state == PEND);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ep          <= 1'b0;
            ep_src      <= '0;
            ccu_ones    <= 1'b0;
            multi_err   <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            ep       <= capture;
            ccu_ones <= |ones_in;

            case (state)
                IDLE: begin
                    if (any_hit) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (ep_ack && !any_hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (capture) begin
                ep_src <= low_idx;
            end

            if (multi_hit) begin
                multi_err <= 1'b1;
            end else if (clr_err) begin
                multi_err <= 1'b0;
            end

            if (ovr_event) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end

            // A clear coinciding with an overrun restarts the count at one.
            if (clr_err) begin
                overrun_cnt <= ovr_event ? CNT_W'(1) : '0;
            end else if (ovr_event && (overrun_cnt != CNT_MAX)) begin
                overrun_cnt <= overrun_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ccu_ep_merge.sv
module tb_ccu_ep_merge;

    localparam int N_EP   = 12;
    localparam int N_ONES = 3;
    localparam int CNT_W  = 4;
    localparam int SW     = 4;
    localparam int CMAX   = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_EP-1:0]   ep_in;
    logic [N_EP-1:0]   ep_en;
    logic [N_ONES-1:0] ones_in;
    logic              ep_ack;
    logic              clr_err;
    logic              ep;
    logic              ep_pending;
    logic [SW-1:0]     ep_src;
    logic              ccu_ones;
    logic              multi_err;
    logic              overrun;
    logic [CNT_W-1:0]  overrun_cnt;

    always #5 clk = ~clk;

    ccu_ep_merge #(.N_EP(N_EP), .N_ONES(N_ONES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ep_in(ep_in), .ep_en(ep_en), .ones_in(ones_in),
        .ep_ack(ep_ack), .clr_err(clr_err), .ep(ep), .ep_pending(ep_pending),
        .ep_src(ep_src), .ccu_ones(ccu_ones), .multi_err(multi_err),
        .overrun(overrun), .overrun_cnt(overrun_cnt)
    );

    typedef struct {
        int ep;
        int pend;
        int src;
        int ones;
        int merr;
        int ovr;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference state: what the MCU should currently be seeing.
    int m_pend = 0, m_src = 0, m_merr = 0, m_ovr = 0, m_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
    endtask

    task automatic drive(input bit rst, input logic [N_EP-1:0] epi, input logic [N_EP-1:0] en,
                         input logic [N_ONES-1:0] ones, input bit ack, input bit clr);
        exp_t e;
        int   nhit, low;
        bit   ovr_ev, cap;
        @(negedge clk);
        rst_n = rst; ep_in = epi; ep_en = en; ones_in = ones; ep_ack = ack; clr_err = clr;
        if (!rst) begin
            m_pend = 0; m_src = 0; m_merr = 0; m_ovr = 0; m_cnt = 0;
            e = '{0, 0, 0, 0, 0, 0, 0};
        end else begin
            nhit = 0;
            low  = -1;
            for (int i = 0; i < N_EP; i++) begin
                if (epi[i] && en[i]) begin
                    nhit++;
                    if (low < 0) low = i;
                end
            end
            ovr_ev = (nhit > 0) && (m_pend == 1) && !ack;
            cap    = (nhit > 0) && ((m_pend == 0) || ack);
            if (cap) begin
                m_pend = 1;
                m_src  = low;
            end else if (m_pend == 1 && ack) begin
                m_pend = 0;
            end
            if (nhit > 1) m_merr = 1;
            else if (clr) m_merr = 0;
            if (ovr_ev) m_ovr = 1;
            else if (clr) m_ovr = 0;
            if (clr) m_cnt = ovr_ev ? 1 : 0;
            else if (ovr_ev && m_cnt < CMAX) m_cnt = m_cnt + 1;
            e = '{int'(cap), m_pend, m_src, int'(ones != 0), m_merr, m_ovr, m_cnt};
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, '0, '1, '0, 0, 0);
    endtask

    // Monitor: every edge that had stimulus behind it is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ep", int'(ep), e.ep);
                chk("ep_pending", int'(ep_pending), e.pend);
                chk("ep_src", int'(ep_src), e.src);
                chk("ccu_ones", int'(ccu_ones), e.ones);
                chk("multi_err", int'(multi_err), e.merr);
                chk("overrun", int'(overrun), e.ovr);
                chk("overrun_cnt", int'(overrun_cnt), e.cnt);
            end
        end
    end

    initial begin
        logic [N_EP-1:0] r_ep, r_en;
        rst_n = 1'b0; ep_in = '0; ep_en = '1; ones_in = '0; ep_ack = 1'b0; clr_err = 1'b0;

        // Reset then single pulse from source 4
        drive(0, '0, '1, '0, 0, 0);
        drive(0, '0, '1, '0, 0, 0);
        drive(1, 12'h010, '1, '0, 0, 0);
        idle(2);
        drive(1, '0, '1, '0, 1, 0);
        idle(1);

        // Simultaneous pulses, then with source 5 masked
        drive(1, 12'h0A0, '1, '0, 0, 0);
        drive(1, '0, '1, '0, 1, 1);
        drive(1, '0, '1, '0, 0, 1);
        drive(1, 12'h0A0, 12'hFDF, '0, 0, 0);
        drive(1, '0, '1, '0, 1, 0);
        idle(1);

        // Overrun saturation
        drive(1, 12'h001, '1, '0, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, 12'h008, '1, '0, 0, 0);
        idle(1);
        drive(1, '0, '1, '0, 0, 1);
        drive(1, '0, '1, '0, 1, 0);

        // Back-to-back ack with new pulse
        drive(1, 12'h004, '1, '0, 0, 0);
        drive(1, 12'h200, '1, '0, 1, 0);
        idle(1);
        drive(1, '0, '1, '0, 1, 0);

        // Ones alignment
        drive(1, 12'h002, '1, 3'b100, 0, 0);
        idle(2);
        drive(1, '0, '1, '0, 1, 0);

        // Clear/set collision, then reset while pending
        drive(1, 12'h040, '1, '0, 0, 0);
        drive(1, 12'h001, '1, '0, 0, 1);
        idle(1);
        drive(0, '0, '1, '0, 0, 0);
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            r_ep = ($urandom_range(0, 1) == 0) ? '0 : N_EP'($urandom & $urandom);
            r_en = ($urandom_range(0, 3) == 0) ? N_EP'($urandom) : '1;
            drive($urandom_range(0, 99) != 0, r_ep, r_en, N_ONES'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
        end

        idle(1);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ccu_ep_merge.md
# ccu_ep_merge

Parametrised end-pulse and sign-pulse merger for the control section: the registered successor of the combinational end-pulse OR stage. It collects N end pulses from the order-execution units and applies per-source enables. It captures the identity of the source that ended and holds the end condition until the main control unit (MCU) acknowledges it. It flags simultaneous and unacknowledged end pulses, and merges the sign insertion/propagation ("ones") pulses with the same one-cycle latency so both streams stay aligned.

## Interface
Parameters:
- N_EP, 12, number of end-pulse sources (1..32)
- N_ONES, 3, number of sign insertion/propagation pulse sources (1..8)
- CNT_W, 4, width of saturating overrun counter (>=1)

Ports (SW = max(1, $clog2(N_EP))):
- clk  in  1  single system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ep_in  in  N_EP  end pulses, bit i from unit i, single-cycle pulses
- ep_en  in  N_EP  per-source enable; ep_in[i] is ignored when ep_en[i]=0
- ones_in  in  N_ONES  sign insertion/propagation pulses
- ep_ack  in  1  MCU has consumed the pending end condition
- clr_err  in  1  clear multi_err, overrun and overrun_cnt
- ep  out  1  one-cycle end pulse to MCU, asserted on each capture
- ep_pending  out  1  an end condition is captured and not yet acknowledged
- ep_src  out  SW  index of captured source; valid while ep_pending=1
- ccu_ones  out  1  registered OR of ones_in
- multi_err  out  1  sticky: more than one enabled end pulse seen in one cycle
- overrun  out  1  sticky: end pulse arrived while pending and not acked
- overrun_cnt  out  CNT_W  saturating count of overrun events

## Operation
- Let hit = ep_in & ep_en. Let any = |hit.
- Two states:
  - IDLE (ep_pending=0)
  - PEND (ep_pending=1)
- IDLE:
  - any=1 -> PEND.
  - ep pulses for one cycle.
  - ep_src := lowest set index of hit.
  - ep_ack is ignored in IDLE.
- PEND, ep_ack=0:
  - Stay in PEND. ep_src is held and ep stays low.
  - any=1 -> overrun event. The new source is discarded and ep_src is not replaced.
- PEND, ep_ack=1, any=0: -> IDLE.
- PEND, ep_ack=1, any=1 (back-to-back):
  - Stay in PEND; this is not an overrun.
  - ep pulses again and ep_src := lowest index of the new hit.
- multi_err:
  - Set whenever popcount(hit)>1 in any state.
  - In IDLE the lowest index still wins.
- Overrun event:
  - Sets overrun.
  - Increments overrun_cnt, saturating at 2^CNT_W-1 (no wrap).
- clr_err:
  - Clears multi_err, overrun and overrun_cnt.
  - Set has priority: an error event in the same cycle as clr_err leaves that flag at 1 and overrun_cnt at 1.
- ccu_ones := |ones_in, registered. It is not masked and is independent of the state machine.
- Disabled sources have no effect on any output, including multi_err and overrun.

## Timing
- Reset (rst_n=0 at a rising edge): after that edge all of the following are 0, and the state is IDLE:
  - ep, ep_pending, ep_src, ccu_ones, multi_err, overrun, overrun_cnt.
- Reset overrides every other input, including mid-PEND; the captured condition is lost.
- Latency:
  - An input sampled at edge k is reflected in outputs after edge k, with no combinational input-to-output path.
  - ep and ccu_ones for the same input cycle are asserted in the same output cycle.
- ep is high for exactly one cycle per capture. ep_pending rises with ep.
- ep_ack sampled at edge k:
  - ep_pending falls after edge k.
  - An ack in the capture cycle itself is impossible: ep_ack is sampled one cycle after ep_in at the earliest.
- Minimum end-to-end handshake: ep_in at edge k, ep_ack at edge k+1, IDLE after k+1.
- ep_src changes only on a capture edge.

## Test plan
- Reset/single pulse:
  - Stimulus: hold rst_n=0 for 2 cycles, then ep_in=12'h010, ep_en=all-ones.
  - Response: all outputs 0 during reset. One cycle later ep=1 (one cycle), ep_pending=1, ep_src=4. Ack -> ep_pending=0 next cycle.
- Simultaneous and masked:
  - Stimulus: ep_in=12'h0A0, ep_en=all-ones.
  - Response: ep_src=5 and multi_err=1.
  - Repeat with ep_en[5]=0: ep_src=7 and multi_err stays 0 after clr_err.
- Overrun saturation (CNT_W=4):
  - Stimulus: capture source 0, then pulse source 3 twenty times without ack.
  - Response: ep_src remains 0, overrun=1, overrun_cnt=15.
  - Then clr_err: all three cleared.
- Back-to-back:
  - Stimulus: in PEND with src 2, apply ep_ack=1 together with ep_in bit 9.
  - Response: ep pulses again, ep_src=9, ep_pending stays 1, overrun=0.
- Ones alignment:
  - Stimulus: ones_in=3'b100 and ep_in bit 1 in the same cycle.
  - Response: ccu_ones and ep are high in the same output cycle, each for exactly one cycle.
- Clear/set collision and reset mid-PEND:
  - Stimulus: clr_err asserted in the same cycle as an overrun event.
  - Response: overrun=1 and overrun_cnt=1.
  - Then rst_n=0 while in PEND: ep_pending=0 and ep_src=0 after the edge.
